lcd_ctrl: RTL and testbench

- Character-LCD (HD44780-compatible, 8-bit bus, write-only) controller downstream of the load-store unit's LCD I/O register.
- Each store to the LCD address produces a one-cycle write strobe plus the 32-bit store word. The word is queued in a small FIFO and replayed to the panel with correct setup, enable-pulse, hold and execution timing.
- Runs the power-up init sequence autonomously. Software never bit-bangs EN.

---
 rtl/lcd_ctrl_if.sv | 49 ++++
 rtl/lcd_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// ============================================================================
// lcd_ctrl_if : store-side strobe/word plus LCD panel bus and status flags
// Rev 1.0
// ============================================================================
`default_nettype none

interface lcd_ctrl_if;
  logic        i_lcd_wr;
  logic [31:0] i_lcd_word;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_init_done;
  logic        o_busy;
  logic        o_full;
  logic        o_overflow;

  modport master (
    output i_lcd_wr,
    output i_lcd_word,
    input  o_lcd_data,
    input  o_lcd_rs,
    input  o_lcd_rw,
    input  o_lcd_en,
    input  o_lcd_on,
    input  o_init_done,
    input  o_busy,
    input  o_full,
    input  o_overflow
  );

  modport slave (
    input  i_lcd_wr,
    input  i_lcd_word,
    output o_lcd_data,
    output o_lcd_rs,
    output o_lcd_rw,
    output o_lcd_en,
    output o_lcd_on,
    output o_init_done,
    output o_busy,
    output o_full,
    output o_overflow
  );
endinterface

`default_nettype wire

// File: rtl/lcd_ctrl.sv
// ============================================================================
// lcd_ctrl : HD44780 8-bit write-only controller with strobe FIFO and init
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int T_PWRUP    = 750000,
  parameter int T_AS       = 2,
  parameter int T_PW       = 12,
  parameter int T_H        = 2,
  parameter int T_EXEC     = 2000,
  parameter int T_CLEAR    = 82000,
  parameter int CNT_W      = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lcd_ctrl_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]    c_depth      = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_pwrup_last = CNT_W'(T_PWRUP - 1);
  localparam logic [CNT_W-1:0] c_as_last    = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] c_pw_last    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] c_exec_last  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] c_clear_last = CNT_W'(T_CLEAR - 1);
  localparam logic [2:0]       c_init_last  = 3'd5;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             init_done_q, init_done_d;
  logic             on_q, on_d;
  logic             ovf_q, ovf_d;

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [8:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_is_clear;
  logic             w_unused;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      default:          init_cmd = 8'h06;
    endcase
  endfunction

  assign w_unused   = ^bus.i_lcd_word[30:9];
  assign w_full     = (count_q == c_depth);
  // A full queue drops the strobe even if the head leaves this same cycle.
  assign w_push     = bus.i_lcd_wr && !w_full;
  assign w_pop      = (state_q == S_IDLE) && init_done_q && (count_q != '0);
  assign w_is_clear = !rs_q && (data_q >= 8'h01) && (data_q <= 8'h03);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    on_d     = on_q;
    ovf_d    = ovf_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = {bus.i_lcd_word[8], bus.i_lcd_word[7:0]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      on_d            = bus.i_lcd_word[31];
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (bus.i_lcd_wr && w_full) begin
      ovf_d = 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    case (state_q)
      // Reset leaves the counter at zero, so power-up counts upward.
      S_PWRUP: begin
        if (cnt_q == c_pwrup_last) begin
          state_d = S_SETUP;
          cnt_d   = c_as_last;
          idx_d   = 3'd0;
          data_d  = init_cmd(3'd0);
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = c_pw_last;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = c_h_last;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = w_is_clear ? c_clear_last : c_exec_last;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (init_done_q) begin
          state_d = S_IDLE;
        end else if (idx_q == c_init_last) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d = S_SETUP;
          cnt_d   = c_as_last;
          idx_d   = idx_q + 3'd1;
          data_d  = init_cmd(idx_q + 3'd1);
          rs_d    = 1'b0;
        end
      end
      S_IDLE: begin
        if (w_pop) begin
          state_d        = S_SETUP;
          cnt_d          = c_as_last;
          {rs_d, data_d} = mem_q[rd_ptr_q];
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase
    en_d = (state_d == S_PULSE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      init_done_q <= init_done_d;
      on_q        <= on_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign bus.o_lcd_data  = data_q;
  assign bus.o_lcd_rs    = rs_q;
  assign bus.o_lcd_rw    = 1'b0;
  assign bus.o_lcd_en    = en_q;
  assign bus.o_lcd_on    = on_q;
  assign bus.o_init_done = init_done_q;
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_full      = w_full;
  assign bus.o_overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// ============================================================================
// tb_lcd_ctrl : directed + randomized self-checking bench for lcd_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int T_PWRUP    = 20;
  localparam int T_AS       = 1;
  localparam int T_PW       = 2;
  localparam int T_H        = 1;
  localparam int T_EXEC     = 5;
  localparam int T_CLEAR    = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T_PWRUP    (T_PWRUP),
    .T_AS       (T_AS),
    .T_PW       (T_PW),
    .T_H        (T_H),
    .T_EXEC     (T_EXEC),
    .T_CLEAR    (T_CLEAR),
    .CNT_W      (20)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log seen on the panel pins
  logic [8:0] q_xfer [$];
  int         q_rise [$];
  int         q_fall [$];
  logic       en_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.o_lcd_en && !en_prev) begin
      q_rise.push_back(cyc);
      q_xfer.push_back({bus.o_lcd_rs, bus.o_lcd_data});
    end
    if (!bus.o_lcd_en && en_prev) q_fall.push_back(cyc);
    en_prev <= bus.o_lcd_en;
  end

  // Reference: expected transfers in panel order
  logic [8:0] q_exp [$];
  int         chk_ptr;
  logic [7:0] init_list [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int exec_of(input logic [8:0] e);
    if (e[8] == 1'b0 && e[7:0] >= 8'd1 && e[7:0] <= 8'd3) return T_CLEAR;
    return T_EXEC;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[7:0] = 8'($urandom_range(0, 4));
    return w;
  endfunction

  task automatic clear_log();
    q_xfer.delete(); q_rise.delete(); q_fall.delete(); q_exp.delete();
    chk_ptr = 0;
  endtask

  task automatic wait_idle(input int budget);
    int stable = 0;
    int t = 0;
    while (stable < 2 && t < budget) begin
      @(negedge clk);
      t++;
      if (!bus.o_busy) stable++; else stable = 0;
    end
    if (stable < 2) timeout_fail("wait_idle");
  endtask

  task automatic verify_log();
    check("xfer_count", 32'(q_xfer.size()), 32'(q_exp.size()));
    for (int i = chk_ptr; i < q_exp.size() && i < q_xfer.size(); i++) begin
      check("xfer_rs_data", 32'(q_xfer[i]), 32'(q_exp[i]));
      if (i < q_fall.size()) check("en_width", 32'(q_fall[i] - q_rise[i]), T_PW);
      else timeout_fail("en_fall");
    end
    chk_ptr = q_exp.size();
  endtask

  // Rise-to-rise distance: AS+PW+H+exec, plus the IDLE cycle outside init
  task automatic spacing(input int from, input int last, input int init_n);
    for (int i = from; i < last && i + 1 < q_rise.size() && i < q_exp.size(); i++)
      check("rise_spacing", 32'(q_rise[i+1] - q_rise[i]),
            32'(T_AS + T_PW + T_H + exec_of(q_exp[i]) + ((i < init_n - 1) ? 0 : 1)));
  endtask

  task automatic do_init(input int n_pre);
    int rel;
    int t;
    logic [31:0] w;
    for (int i = 0; i < 6; i++) q_exp.push_back({1'b0, init_list[i]});
    rel = cyc;
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < n_pre; i++) begin
      w = rand_word();
      bus.i_lcd_wr = 1'b1; bus.i_lcd_word = w;
      @(negedge clk);
      bus.i_lcd_wr = 1'b0;
      q_exp.push_back({w[8], w[7:0]});
      check("pwrup_strobe_on", 32'(bus.o_lcd_on), 32'(w[31]));
      check("pwrup_no_done", 32'(bus.o_init_done), 0);
    end
    t = 0;
    while (!bus.o_init_done && t < 300) begin @(negedge clk); t++; end
    if (!bus.o_init_done) timeout_fail("init_done_wait");
    else begin
      check("init_done_cycle", 32'(cyc - rel), 32'(T_PWRUP + 5*9 + 14));
      check("busy_at_done", 32'(bus.o_busy), 0);
    end
    wait_idle(400);
    verify_log();
    if (q_rise.size() > 0) check("first_rise", 32'(q_rise[0] - rel), 32'(T_PWRUP + T_AS));
    spacing(0, q_exp.size() - 1, 6);
  endtask

  task automatic single_write(input logic [31:0] w);
    int t;
    int len;
    bus.i_lcd_wr = 1'b1; bus.i_lcd_word = w;
    @(negedge clk);
    bus.i_lcd_wr = 1'b0;
    q_exp.push_back({w[8], w[7:0]});
    check("wr_on_next", 32'(bus.o_lcd_on), 32'(w[31]));
    t = 0;
    while (!bus.o_busy && t < 10) begin @(negedge clk); t++; end
    if (!bus.o_busy) timeout_fail("busy_rise");
    len = 0;
    while (bus.o_busy && len < 200) begin @(negedge clk); len++; end
    check("busy_len", 32'(len), 32'(T_AS + T_PW + T_H + exec_of({w[8], w[7:0]})));
    tick(2);
    verify_log();
    check("data_hold", 32'(bus.o_lcd_data), 32'(w[7:0]));
    check("rs_hold", 32'(bus.o_lcd_rs), 32'(w[8]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int base;
    int t;
    rst_n = 1'b0;
    bus.i_lcd_wr = 1'b0;
    bus.i_lcd_word = '0;
    tick(3);

    // Reset state
    check("rst_en", 32'(bus.o_lcd_en), 0);
    check("rst_data", 32'(bus.o_lcd_data), 0);
    check("rst_rs", 32'(bus.o_lcd_rs), 0);
    check("rst_rw", 32'(bus.o_lcd_rw), 0);
    check("rst_on", 32'(bus.o_lcd_on), 0);
    check("rst_done", 32'(bus.o_init_done), 0);
    check("rst_busy", 32'(bus.o_busy), 1);
    check("rst_full", 32'(bus.o_full), 0);
    check("rst_ovf", 32'(bus.o_overflow), 0);
    clear_log();

    // Init with two strobes queued during power-up
    do_init(2);

    // Directed and random single writes
    single_write(32'h8000_0141);
    single_write(32'h0000_0001);
    single_write(32'h0000_000C);
    for (int i = 0; i < 6; i++) single_write(rand_word());

    // Burst of 6 while a clear command executes: 4 fit, 2 dropped
    check("pre_burst_ovf", 32'(bus.o_overflow), 0);
    base = q_exp.size();
    bus.i_lcd_wr = 1'b1; bus.i_lcd_word = 32'h0000_0001;
    @(negedge clk);
    bus.i_lcd_wr = 1'b0;
    q_exp.push_back(9'h001);
    t = 0;
    while (!bus.o_busy && t < 10) begin @(negedge clk); t++; end
    if (!bus.o_busy) timeout_fail("burst_busy");
    for (int k = 0; k < 6; k++) begin
      w = rand_word();
      bus.i_lcd_wr = 1'b1; bus.i_lcd_word = w;
      if (k < FIFO_DEPTH) q_exp.push_back({w[8], w[7:0]});
      @(negedge clk);
      if (k == FIFO_DEPTH - 1) check("burst_on_last_accepted", 32'(bus.o_lcd_on), 32'(w[31]));
    end
    bus.i_lcd_wr = 1'b0;
    check("burst_full", 32'(bus.o_full), 1);
    check("burst_ovf", 32'(bus.o_overflow), 1);
    wait_idle(400);
    verify_log();
    spacing(base, base + FIFO_DEPTH, 0);
    check("ovf_sticky", 32'(bus.o_overflow), 1);
    check("drained_full", 32'(bus.o_full), 0);

    // Reset in the middle of an EN pulse with a full queue
    for (int k = 0; k < 5; k++) begin
      w = rand_word();
      w[31] = 1'b1;
      bus.i_lcd_wr = 1'b1; bus.i_lcd_word = w;
      @(negedge clk);
    end
    bus.i_lcd_wr = 1'b0;
    check("pre_rst_full", 32'(bus.o_full), 1);
    t = 0;
    while (!bus.o_lcd_en && t < 100) begin @(negedge clk); t++; end
    if (!bus.o_lcd_en) timeout_fail("en_before_reset");
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_en", 32'(bus.o_lcd_en), 0);
    check("mid_rst_full", 32'(bus.o_full), 0);
    check("mid_rst_done", 32'(bus.o_init_done), 0);
    check("mid_rst_on", 32'(bus.o_lcd_on), 0);
    check("mid_rst_ovf", 32'(bus.o_overflow), 0);
    check("mid_rst_busy", 32'(bus.o_busy), 1);
    check("mid_rst_data", 32'(bus.o_lcd_data), 0);
    tick(2);
    clear_log();
    do_init(0);
    tick(5);
    check("no_stale_replay", 32'(q_xfer.size()), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
